multichannel_wr_arbiter: RTL

MULTICHANNEL_WR_ARBITER -- requirements
Module: multichannel_wr_arbiter

---
 rtl/arb_pkg.sv | 22 ++
 rtl/wr_rr_pick.sv | 35 +++
 rtl/multichannel_wr_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: definitions shared by the write-side and read-side channel arbiters.
//   NUM_CH      : number of arbitrated channels (4)
//   CH_W        : width of a channel index
//   arb_state_t : one-hot IDLE / GRANT / BUSY state encoding
//   ch_onehot() : channel index -> one-hot channel vector
package arb_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_GRANT = 3'b010,
    ST_BUSY  = 3'b100
  } arb_state_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
    ch_onehot      = '0;
    ch_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/wr_rr_pick.sv
// wr_rr_pick: combinational rotating-priority picker.
// Searches req starting at channel ptr, then ptr+1, ... (mod NUM_CH) and
// returns the first requesting channel.
// Ports:
//   req   [NUM_CH-1:0] in  : request vector
//   ptr   [CH_W-1:0]   in  : highest-priority channel this round
//   valid              out : at least one request present
//   idx   [CH_W-1:0]   out : selected channel (0 when valid is low)
module wr_rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              valid,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the channel closest to
  // ptr overwrites any earlier hit and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr + CH_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/multichannel_wr_arbiter.sv
// multichannel_wr_arbiter: 4-channel rotating-priority arbiter in front of a
// single AXI write master. A granted channel's address/length are latched
// and held until the burst completes.
// Optional feature: define WR_TIMEOUT_EN to add a BUSY watchdog of
// TIMEOUT_CYC cycles that releases a stuck grant and pulses wr_timeout.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   wr_req[3:0]                   : per-channel level requests
//   wr_addr0..3 / wr_len0..3      : per-channel burst address / length
//   wr_grant[3:0]                 : one-hot grant (GRANT and BUSY states)
//   wr_done                       : burst-complete pulse from the AXI master
//   axi_wr_start                  : one-cycle burst start pulse
//   axi_wr_addr / axi_wr_len      : latched burst parameters
//   wr_timeout                    : watchdog expiry pulse (0 without feature)
module multichannel_wr_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [ADDR_W-1:0] wr_addr2,
  input  logic [ADDR_W-1:0] wr_addr3,
  input  logic [LEN_W-1:0]  wr_len0,
  input  logic [LEN_W-1:0]  wr_len1,
  input  logic [LEN_W-1:0]  wr_len2,
  input  logic [LEN_W-1:0]  wr_len3,
  output logic [3:0]        wr_grant,
  input  logic              wr_done,
  output logic              axi_wr_start,
  output logic [ADDR_W-1:0] axi_wr_addr,
  output logic [LEN_W-1:0]  axi_wr_len,
  output logic              wr_timeout
);

  // Reject watchdog limits the counter compare cannot represent.
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout_cfg
    $error("multichannel_wr_arbiter: TIMEOUT_CYC must be >= 2");
  end

  arb_state_t       state_q, state_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [ADDR_W-1:0] addr_arr [NUM_CH];
  logic [LEN_W-1:0]  len_arr  [NUM_CH];

  assign addr_arr[0] = wr_addr0;
  assign addr_arr[1] = wr_addr1;
  assign addr_arr[2] = wr_addr2;
  assign addr_arr[3] = wr_addr3;
  assign len_arr[0]  = wr_len0;
  assign len_arr[1]  = wr_len1;
  assign len_arr[2]  = wr_len2;
  assign len_arr[3]  = wr_len3;

  logic            pick_valid;
  logic [CH_W-1:0] pick_idx;

  wr_rr_pick u_pick (
    .req   (wr_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef WR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;

  // cnt_q holds (BUSY cycle number - 1), so expiry lands on BUSY cycle
  // TIMEOUT_CYC itself.
  assign expire = (state_q == ST_BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          addr_d  = addr_arr[pick_idx];
          len_d   = len_arr[pick_idx];
        end
      end
      ST_GRANT: state_d = ST_BUSY;
      ST_BUSY: begin
        // wr_done is checked first so it beats a same-cycle expiry.
        if (wr_done) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q + CH_W'(1);
        end
`ifdef WR_TIMEOUT_EN
        else if (expire) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q + CH_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef WR_TIMEOUT_EN
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_BUSY && state_d == ST_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign wr_timeout = expire && !wr_done;
`else
  assign wr_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  assign wr_grant     = (state_q == ST_GRANT || state_q == ST_BUSY) ? ch_onehot(sel_q) : '0;
  assign axi_wr_start = (state_q == ST_GRANT);
  assign axi_wr_addr  = addr_q;
  assign axi_wr_len   = len_q;

endmodule
